// File: rtl/sr04_pkg.sv
// Shared types and constants for the HC-SR04 ranger.
// Cycle-count helpers are evaluated at elaboration time from the clock frequency.
package sr04_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_TRIG      = 3'd1,
    S_WAIT_RISE = 3'd2,
    S_MEASURE   = 3'd3,
    S_DONE      = 3'd4,
    S_HOLD      = 3'd5
  } sr04_state_e;

  localparam int MAX_MM     = 32'sd9999;
  // Speed of sound in mm/s; echo time covers the round trip.
  localparam int SOUND_MM_S = 32'sd343000;

  function automatic int us_cycles(input int clk_hz, input int us);
    longint prod;
    prod = longint'(clk_hz) * longint'(us);
    return int'(prod / 64'sd1000000);
  endfunction

  // Clock cycles per millimetre of distance, rounded to nearest.
  function automatic int mm_cycles(input int clk_hz);
    longint num;
    num = 64'sd2 * longint'(clk_hz) + longint'(SOUND_MM_S / 32'sd2);
    return int'(num / longint'(SOUND_MM_S));
  endfunction

endpackage

// File: rtl/sr04_avg4.sv
// Four-sample moving average of distance readings (used with SR04_AVG_EN).
// The first sample after reset fills the whole history so the output starts settled.
module sr04_avg4
  import sr04_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_vld,
  input  logic [15:0] sample,
  output logic [15:0] avg,
  output logic        avg_vld
);

  logic [15:0] hist0_r, hist1_r, hist2_r;
  logic        primed_r;
  logic [17:0] sum_s;

  // Sum of the incoming sample with the three most recent history entries.
  always_comb begin
    sum_s = 18'(sample) + 18'(hist0_r) + 18'(hist1_r) + 18'(hist2_r);
  end

  // History shift register, preload on first sample and registered average.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist0_r  <= 16'd0;
      hist1_r  <= 16'd0;
      hist2_r  <= 16'd0;
      primed_r <= 1'b0;
      avg      <= 16'd0;
      avg_vld  <= 1'b0;
    end else begin
      avg_vld <= sample_vld;
      if (sample_vld) begin
        if (!primed_r) begin
          hist0_r  <= sample;
          hist1_r  <= sample;
          hist2_r  <= sample;
          primed_r <= 1'b1;
          avg      <= sample;
        end else begin
          hist2_r <= hist1_r;
          hist1_r <= hist0_r;
          hist0_r <= sample;
          avg     <= sum_s[17:2];
        end
      end
    end
  end

endmodule

// File: rtl/sr04_ranger.sv
// HC-SR04 driver: periodic trigger, echo timing and mm conversion saturated at 9999.
// Define SR04_AVG_EN to smooth `data` through a 4-sample moving average.
module sr04_ranger
  import sr04_pkg::*;
#(
  parameter int CLK_HZ     = 32'sd50_000_000,
  parameter int TRIG_US    = 32'sd10,
  parameter int PERIOD_MS  = 32'sd60,
  parameter int TIMEOUT_US = 32'sd30000
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        en,
  input  logic        echo,
  output logic        trig,
  output logic [15:0] data,
  output logic        data_vld,
  output logic        err
);

  localparam int TRIG_CYC   = us_cycles(CLK_HZ, TRIG_US);
  localparam int PERIOD_CYC = us_cycles(CLK_HZ, PERIOD_MS * 32'sd1000);
  localparam int TMO_CYC    = us_cycles(CLK_HZ, TIMEOUT_US);
  localparam int MM_CYC     = mm_cycles(CLK_HZ);
  localparam int CNT_W      = $clog2(TRIG_CYC + TMO_CYC + 2);
  localparam int PER_W      = $clog2(PERIOD_CYC + 1);
  localparam int SUB_W      = $clog2(MM_CYC + 1);
  localparam int MM_W       = 14;

  sr04_state_e      state_r;
  logic [1:0]       sync_r;
  logic             echo_prev_r;
  logic [CNT_W-1:0] cnt_r;
  logic [PER_W-1:0] per_cnt_r;
  logic [SUB_W-1:0] sub_r;
  logic [MM_W-1:0]  mm_r;
  logic [15:0]      sample_r;
  logic             sample_vld_r;
  logic             trig_r;
  logic             err_r;

  logic             rise_s, fall_s;
  logic [SUB_W-1:0] sub_base_s, sub_inc_s;
  logic [MM_W-1:0]  mm_base_s, mm_inc_s;

  assign rise_s = sync_r[1] & ~echo_prev_r;
  assign fall_s = ~sync_r[1] & echo_prev_r;

  // Next value of the distance counters; the rise cycle counts from zero so width is exact.
  always_comb begin
    sub_base_s = (state_r == S_MEASURE) ? sub_r : {SUB_W{1'b0}};
    mm_base_s  = (state_r == S_MEASURE) ? mm_r  : {MM_W{1'b0}};
    if (sub_base_s == SUB_W'(MM_CYC - 1)) begin
      sub_inc_s = {SUB_W{1'b0}};
      mm_inc_s  = (mm_base_s == MM_W'(MAX_MM)) ? mm_base_s : mm_base_s + 14'd1;
    end else begin
      sub_inc_s = sub_base_s + {{(SUB_W-1){1'b0}}, 1'b1};
      mm_inc_s  = mm_base_s;
    end
  end

  // Echo synchroniser, ranging FSM and registered outputs.
  always_ff @(posedge clk) begin
    if (RST) begin
      state_r      <= S_IDLE;
      sync_r       <= 2'b00;
      echo_prev_r  <= 1'b0;
      cnt_r        <= {CNT_W{1'b0}};
      per_cnt_r    <= {PER_W{1'b0}};
      sub_r        <= {SUB_W{1'b0}};
      mm_r         <= {MM_W{1'b0}};
      sample_r     <= 16'd0;
      sample_vld_r <= 1'b0;
      trig_r       <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      sync_r       <= {sync_r[0], echo};
      echo_prev_r  <= sync_r[1];
      sample_vld_r <= 1'b0;
      if (state_r != S_IDLE) begin
        per_cnt_r <= per_cnt_r + {{(PER_W-1){1'b0}}, 1'b1};
      end
      case (state_r)
        S_IDLE: begin
          if (en) begin
            state_r   <= S_TRIG;
            trig_r    <= 1'b1;
            cnt_r     <= {CNT_W{1'b0}};
            // The IDLE cycle is part of the period, so trigger rises repeat exactly.
            per_cnt_r <= {{(PER_W-1){1'b0}}, 1'b1};
          end
        end
        S_TRIG: begin
          if (cnt_r == CNT_W'(TRIG_CYC - 1)) begin
            trig_r  <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
            state_r <= S_WAIT_RISE;
          end else begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        S_WAIT_RISE: begin
          if (cnt_r == CNT_W'(TMO_CYC)) begin
            err_r   <= 1'b1;
            state_r <= S_HOLD;
          end else begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            if (rise_s) begin
              state_r <= S_MEASURE;
              sub_r   <= sub_inc_s;
              mm_r    <= mm_inc_s;
            end
          end
        end
        S_MEASURE: begin
          if (fall_s) begin
            sample_r     <= {2'b00, mm_r};
            sample_vld_r <= 1'b1;
            err_r        <= 1'b0;
            state_r      <= S_DONE;
          end else if (cnt_r == CNT_W'(TMO_CYC)) begin
            err_r   <= 1'b1;
            state_r <= S_HOLD;
          end else begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            sub_r <= sub_inc_s;
            mm_r  <= mm_inc_s;
          end
        end
        S_DONE: begin
          state_r <= S_HOLD;
        end
        S_HOLD: begin
          if (per_cnt_r == PER_W'(PERIOD_CYC - 1)) begin
            state_r <= S_IDLE;
          end
        end
        default: begin
          state_r <= S_IDLE;
          trig_r  <= 1'b0;
        end
      endcase
    end
  end

  assign trig = trig_r;
  assign err  = err_r;

`ifdef SR04_AVG_EN
  sr04_avg4 u_avg4 (
    .clk        (clk),
    .rst        (RST),
    .sample_vld (sample_vld_r),
    .sample     (sample_r),
    .avg        (data),
    .avg_vld    (data_vld)
  );
`else
  assign data     = sample_r;
  assign data_vld = sample_vld_r;
`endif

endmodule

// File: tb/tb_sr04_ranger.sv
// Directed bench for sr04_ranger with a scoreboard of expected distances.
// Honours SR04_AVG_EN by switching its expected-value model to the 4-sample average.
module tb_sr04_ranger;

  logic        clk = 1'b0;
  logic        RST, en, echo, trig, data_vld, err;
  logic [15:0] data;
  logic        en_sat, echo_sat, trig_sat, data_vld_sat, err_sat;
  logic [15:0] data_sat;

`ifdef SR04_AVG_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif
  localparam int TMO    = 4000;
  localparam int PERIOD = 7000;

  sr04_ranger #(.CLK_HZ(1_000_000), .TRIG_US(10), .PERIOD_MS(7), .TIMEOUT_US(4000)) dut (
    .clk(clk), .RST(RST), .en(en), .echo(echo),
    .trig(trig), .data(data), .data_vld(data_vld), .err(err)
  );

  // 100 kHz clock: 1 cycle per mm, 10-cycle trigger, 15000-cycle timeout
  sr04_ranger #(.CLK_HZ(100_000), .TRIG_US(100), .PERIOD_MS(200), .TIMEOUT_US(150000)) dut_sat (
    .clk(clk), .RST(RST), .en(en_sat), .echo(echo_sat),
    .trig(trig_sat), .data(data_sat), .data_vld(data_vld_sat), .err(err_sat)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vld_cnt = 0;
  always @(posedge clk) if (data_vld === 1'b1) vld_cnt <= vld_cnt + 1;

  int n_cmp = 0;
  int n_fail = 0;
  int exp_q[$];
  int hist[4];
  bit primed = 1'b0;
  int last_data = 0;
  int echo_fall_cyc = 0;

  function automatic int raw_mm(int w, int mm_cyc);
    int v;
    v = w / mm_cyc;
    return (v > 9999) ? 9999 : v;
  endfunction

  task automatic check(string tag, int obs, int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_sample(int mm);
`ifdef SR04_AVG_EN
    if (!primed) begin
      for (int i = 0; i < 4; i++) hist[i] = mm;
      primed = 1'b1;
    end else begin
      hist[3] = hist[2];
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = mm;
    end
    exp_q.push_back((hist[0] + hist[1] + hist[2] + hist[3]) >> 2);
`else
    exp_q.push_back(mm);
`endif
  endtask

  task automatic wait_trig(logic lvl, int bound, string tag);
    int n;
    n = 0;
    while (trig !== lvl && n < bound) begin
      tick(1);
      n++;
    end
    check(tag, int'(trig), int'(lvl));
  endtask

  task automatic drive_echo(int w);
    echo = 1'b1;
    tick(w);
    echo = 1'b0;
    echo_fall_cyc = cyc;
    push_sample(raw_mm(w, 6));
  endtask

  task automatic expect_result();
    int n;
    int exp;
    n = 0;
    while (data_vld !== 1'b1 && n < 20) begin
      tick(1);
      n++;
    end
    check("data_vld_seen", int'(data_vld), 1);
    check("vld_latency", cyc - echo_fall_cyc, LAT);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    check("data", int'(data), exp);
    last_data = exp;
    tick(1);
    check("vld_single", int'(data_vld), 0);
  endtask

  initial begin
    int c0, rise1, f, v0, n;
    RST = 1'b1; en = 1'b1; echo = 1'b0;
    en_sat = 1'b0; echo_sat = 1'b0;
    tick(3);
    check("rst_trig", int'(trig), 0);
    check("rst_data", int'(data), 0);
    check("rst_vld", int'(data_vld), 0);
    check("rst_err", int'(err), 0);

    // First trigger: 1 cycle after release, 10 cycles wide
    RST = 1'b0;
    c0 = cyc;
    wait_trig(1'b1, 5, "trig_rise1");
    check("trig_delay", cyc - c0, 1);
    rise1 = cyc;
    n = 0;
    while (trig === 1'b1 && n < 50) begin
      tick(1);
      n++;
    end
    check("trig_width", n, 10);
    tick(20);
    drive_echo(600);
    expect_result();
    check("err_after_600", int'(err), 0);

    // Second period: exact spacing, then no echo -> timeout
    wait_trig(1'b1, PERIOD + 10, "trig_rise2");
    check("period", cyc - rise1, PERIOD);
    wait_trig(1'b0, 20, "trig_fall2");
    f = cyc;
    v0 = vld_cnt;
    tick(TMO - 5);
    check("err_before_tmo", int'(err), 0);
    tick(10);
    check("err_after_tmo", int'(err), 1);
    check("data_kept_tmo", int'(data), last_data);
    check("no_vld_tmo", vld_cnt, v0);

    // Three 1200-cycle echoes
    for (int p = 0; p < 3; p++) begin
      wait_trig(1'b1, PERIOD + 10, "trig_rise_p");
      wait_trig(1'b0, 20, "trig_fall_p");
      tick(20);
      drive_echo(1200);
      expect_result();
      check("err_cleared", int'(err), 0);
    end
    check("vld_count", vld_cnt, 4);

    // Reset in the middle of a measurement
    wait_trig(1'b1, PERIOD + 10, "trig_rise_r");
    wait_trig(1'b0, 20, "trig_fall_r");
    tick(20);
    echo = 1'b1;
    tick(300);
    RST = 1'b1;
    tick(1);
    check("rstm_trig", int'(trig), 0);
    check("rstm_data", int'(data), 0);
    check("rstm_err", int'(err), 0);
    check("rstm_vld", int'(data_vld), 0);
    echo = 1'b0;
    tick(2);
    RST = 1'b0;
    c0 = cyc;
    wait_trig(1'b1, 5, "trig_restart");
    check("restart_delay", cyc - c0, 1);

    // Reset while the trigger is high drops it on the next edge
    tick(3);
    RST = 1'b1;
    tick(1);
    check("rst_mid_trig", int'(trig), 0);
    en = 1'b0;
    RST = 1'b0;
    tick(2);

    // Saturation: 12000 mm of echo at 1 cycle/mm clamps to 9999
    en_sat = 1'b1;
    n = 0;
    while (trig_sat !== 1'b1 && n < 5) begin tick(1); n++; end
    check("sat_trig_rise", int'(trig_sat), 1);
    n = 0;
    while (trig_sat !== 1'b0 && n < 20) begin tick(1); n++; end
    check("sat_trig_fall", int'(trig_sat), 0);
    tick(5);
    echo_sat = 1'b1;
    tick(12000);
    echo_sat = 1'b0;
    n = 0;
    while (data_vld_sat !== 1'b1 && n < 20) begin tick(1); n++; end
    check("sat_vld_seen", int'(data_vld_sat), 1);
    check("sat_data", int'(data_sat), raw_mm(12000, 1));
    check("sat_err", int'(err_sat), 0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
